// File: rtl/seq_cla_adder_if.sv
// Handshake and data bundle between an operand producer, the iterative
// adder and a result consumer. The master side is the producer/consumer
// pair, the slave side is the adder itself.
interface seq_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/seq_cla_adder.sv
// Iterative WIDTH-bit adder/subtractor built around one 4-bit
// carry-lookahead slice. One nibble is processed per clock, LSB first;
// the inter-nibble carry is rebuilt from the slice's group P/G outputs.

// 4-bit carry-lookahead slice: nibble sum plus group propagate/generate.
module CLA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    // Bit propagate/generate, internal lookahead carries, sum and group terms.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
        pg   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

module seq_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    seq_cla_adder_if.slave   bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NIB - 1);
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_eff;
    logic             carry;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [IDXW+1:0]  shamt;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_s;
    logic             slice_pg;
    logic             slice_gg;
    logic             carry_next;
    logic [WIDTH-1:0] sum_merge;
    logic             ovf_next;
    logic             last_nib;

    CLA u_cla (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry),
        .s   (slice_s),
        .pg  (slice_pg),
        .gg  (slice_gg)
    );

    // Select the current nibble with shifts so the index never needs a
    // wide part-select, then merge the slice result back into the sum.
    always_comb begin
        shamt      = {idx, 2'b00};
        a_shift    = a_reg >> shamt;
        b_shift    = b_eff >> shamt;
        slice_a    = a_shift[3:0];
        slice_b    = b_shift[3:0];
        carry_next = slice_gg | (slice_pg & carry);
        sum_merge  = (sum_reg & ~(NIB_MASK << shamt))
                   | (WIDTH'(slice_s) << shamt);
        last_nib   = (idx == LAST_IDX);
        ovf_next   = (a_reg[WIDTH-1] == b_eff[WIDTH-1])
                   & (slice_s[3] != a_reg[WIDTH-1]);
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, step nibbles in RUN, hold in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (last_nib) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, fold one nibble per RUN cycle,
    // and capture carry-out/overflow together with the top nibble.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            a_reg    <= '0;
            b_eff    <= '0;
            carry    <= 1'b0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg    <= bus.a;
                        b_eff    <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub ? 1'b1 : bus.cin;
                        idx      <= '0;
                        sum_reg  <= '0;
                        cout_reg <= 1'b0;
                        ovf_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_reg <= sum_merge;
                    carry   <= carry_next;
                    if (last_nib) begin
                        cout_reg <= carry_next;
                        ovf_reg  <= ovf_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags are pure state decodes; results come straight from registers.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.sum       = sum_reg;
        bus.cout      = cout_reg;
        bus.ovf       = ovf_reg;
    end
endmodule
